// File: rtl/srl16_tap_delay_pkg.sv
`default_nettype none
// ============================================================================
// srl16_tap_delay_pkg : shared constants for SRL16-style tap delay lines
// Revision : 1.0
// ============================================================================
package srl16_tap_delay_pkg;

  localparam int SRL_DEPTH  = 16;
  localparam int SRL_ADDR_W = $clog2(SRL_DEPTH);

endpackage
`default_nettype wire

// File: rtl/srl16_lane.sv
`default_nettype none
// ============================================================================
// srl16_lane : one-bit shift chain with an asynchronous tap-select read mux
// Revision : 1.0
// ============================================================================
module srl16_lane #(
  parameter int               DEPTH = 16,
  parameter logic [DEPTH-1:0] INIT  = '0
) (
  input  logic                     core_clk,
  input  logic                     core_rst,
  input  logic                     ce,
  input  logic                     d,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic                     q
);

  // Power-up contents match the reset contents, as on the SRL16E primitive.
  logic [DEPTH-1:0] sr_q = INIT;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (ce) begin
      sr_d = {sr_q[DEPTH-2:0], d};
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      sr_q <= INIT;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[addr];

endmodule
`default_nettype wire

// File: rtl/srl16_tap_delay.sv
`default_nettype none
// ============================================================================
// srl16_tap_delay : WIDTH-lane variable-tap delay line (SRL16E + sync reset)
// Revision : 1.0
// ============================================================================
module srl16_tap_delay
  import srl16_tap_delay_pkg::*;
#(
  parameter int                     WIDTH = 1,
  parameter int                     DEPTH = SRL_DEPTH,
  parameter logic [WIDTH*DEPTH-1:0] INIT  = '0
) (
  input  logic                     core_clk,
  input  logic                     core_rst,
  input  logic                     ce,
  input  logic [WIDTH-1:0]         d,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [WIDTH-1:0]         q
);

  // Lane w owns INIT bits [w*DEPTH +: DEPTH]; all lanes share ce and addr.
  for (genvar w = 0; w < WIDTH; w++) begin : g_lane
    srl16_lane #(
      .DEPTH (DEPTH),
      .INIT  (INIT[w*DEPTH +: DEPTH])
    ) u_lane (
      .core_clk (core_clk),
      .core_rst (core_rst),
      .ce       (ce),
      .d        (d[w]),
      .addr     (addr),
      .q        (q[w])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_srl16_tap_delay.sv
`default_nettype none
// ============================================================================
// tb_srl16_tap_delay : directed self-checking bench for srl16_tap_delay
// Revision : 1.0
// ============================================================================
module tb_srl16_tap_delay;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] d16;
  logic [3:0]  a16;
  logic [15:0] q16;
  logic        d1;
  logic [3:0]  a1;
  logic [0:0]  q1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  srl16_tap_delay #(.WIDTH(16)) dut16 (
    .core_clk (clk),
    .core_rst (rst),
    .ce       (ce),
    .d        (d16),
    .addr     (a16),
    .q        (q16)
  );

  srl16_tap_delay #(.WIDTH(1), .INIT(16'h0020)) dut1 (
    .core_clk (clk),
    .core_rst (rst),
    .ce       (ce),
    .d        (d1),
    .addr     (a1),
    .q        (q1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_powerup();
    a1 = 4'd5;
    #1;
    tests_run++;
    if (q1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL powerup_init q=%b expected=1", q1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; d16 = 16'hFFFF; d1 = 1'b1;
    step();
    step();
    rst = 1'b0; ce = 1'b0; d1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a16 = 4'(k);
      #1;
      tests_run++;
      if (q16 !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset addr=%0d q=%h expected=0000", k, q16);
      end
    end
  endtask

  task automatic test_fixed_delay(input int a);
    logic [15:0] exp;
    rst = 1'b1; ce = 1'b0; d16 = 16'h0000;
    step();
    rst = 1'b0; ce = 1'b1; a16 = 4'(a);
    d16 = 16'hFFFF;
    for (int k = 1; k <= 18; k++) begin
      step();
      d16 = 16'h0000;
      exp = (k == a + 1) ? 16'hFFFF : 16'h0000;
      tests_run++;
      if (q16 !== exp) begin
        tests_failed++;
        $display("FAIL fixed_delay addr=%0d edge=%0d q=%h expected=%h", a, k, q16, exp);
      end
    end
    ce = 1'b0;
  endtask

  task automatic test_dynamic();
    logic [15:0] exp;
    rst = 1'b1; ce = 1'b0;
    step();
    rst = 1'b0; ce = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d16 = 16'h0001 << i;
      step();
    end
    ce = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a16 = 4'(k);
      #1;
      exp = 16'h0001 << (15 - k);
      tests_run++;
      if (q16 !== exp) begin
        tests_failed++;
        $display("FAIL dynamic_tap addr=%0d q=%h expected=%h", k, q16, exp);
      end
    end
  endtask

  task automatic test_clock_enable();
    logic [15:0] exp;
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d16 = 16'($urandom);
      step();
    end
    for (int k = 0; k < 16; k++) begin
      a16 = 4'(k);
      #1;
      exp = 16'h0001 << (15 - k);
      tests_run++;
      if (q16 !== exp) begin
        tests_failed++;
        $display("FAIL ce_hold addr=%0d q=%h expected=%h", k, q16, exp);
      end
    end
    // Two enabled edges separated by two disabled ones: net shift of 2.
    d16 = 16'h0000;
    ce = 1'b1; step();
    ce = 1'b0; step(); step();
    ce = 1'b1; step();
    ce = 1'b0;
    a16 = 4'd15; #1;
    tests_run++;
    if (q16 !== 16'h0004) begin
      tests_failed++;
      $display("FAIL ce_resume_tap15 q=%h expected=0004", q16);
    end
    a16 = 4'd2; #1;
    tests_run++;
    if (q16 !== 16'h8000) begin
      tests_failed++;
      $display("FAIL ce_resume_tap2 q=%h expected=8000", q16);
    end
    a16 = 4'd0; #1;
    tests_run++;
    if (q16 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL ce_resume_tap0 q=%h expected=0000", q16);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    ce = 1'b1; d16 = 16'hFFFF; a16 = 4'd7;
    for (int i = 0; i < 16; i++) step();
    tests_run++;
    if (q16 !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL reset_mid_fill q=%h expected=ffff", q16);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    d16 = 16'h0000;
    tests_run++;
    if (q16 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_mid_clear q=%h expected=0000", q16);
    end
    d16 = 16'hFFFF;
    for (int k = 1; k <= 10; k++) begin
      step();
      d16 = 16'h0000;
      exp = (k == 8) ? 16'hFFFF : 16'h0000;
      tests_run++;
      if (q16 !== exp) begin
        tests_failed++;
        $display("FAIL reset_mid_pulse edge=%0d q=%h expected=%h", k, q16, exp);
      end
    end
    ce = 1'b0;
  endtask

  task automatic test_nonzero_init();
    rst = 1'b1; ce = 1'b0; d1 = 1'b1;
    step();
    rst = 1'b0;
    a1 = 4'd5; #1;
    tests_run++;
    if (q1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_tap5 q=%b expected=1", q1);
    end
    a1 = 4'd4; #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_tap4 q=%b expected=0", q1);
    end
    ce = 1'b1; d1 = 1'b0;
    step();
    ce = 1'b0;
    a1 = 4'd6; #1;
    tests_run++;
    if (q1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_shift_tap6 q=%b expected=1", q1);
    end
    a1 = 4'd5; #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_shift_tap5 q=%b expected=0", q1);
    end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; d16 = 16'h0000; a16 = 4'd0; d1 = 1'b0; a1 = 4'd0;
    test_powerup();
    test_reset();
    test_fixed_delay(3);
    test_fixed_delay(4);
    test_fixed_delay(15);
    test_fixed_delay(0);
    test_dynamic();
    test_clock_enable();
    test_reset_mid();
    test_nonzero_init();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
